// File: rtl/main_mem.sv
// Backing-memory responder for the dcache MSHR: in-order request FIFO, fixed-latency service, tagged responses.
// Optional MAIN_MEM_INIT_EN loads the array from INIT_IMAGE at time 0; otherwise the array starts zeroed.
module main_mem #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 4,
  parameter int    QDEPTH    = 2,
  parameter int    TAG_W     = 2,
  parameter string INIT_FILE = "sim/mem_init.hex",
  parameter int    INIT_N    = 4,
  parameter logic [INIT_N*32-1:0] INIT_IMAGE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_we,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  output logic             busy
);

  // state  | meaning
  // IDLE   | nothing in service, waiting for the FIFO to fill
  // WAIT   | request in service, counting down the access latency
  // RESP   | response presented, waiting for resp_ready
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int AW  = $clog2(DEPTH);
  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [QAW:0]   Q_FULL   = (QAW + 1)'(QDEPTH);

  typedef logic [31:0] mem_t [DEPTH];

`ifdef MAIN_MEM_INIT_EN
  function automatic mem_t f_init_image();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (i < INIT_N) ? INIT_IMAGE[i*32 +: 32] : 32'h0;
    end
    return m;
  endfunction

  logic [31:0] r_mem [DEPTH] = f_init_image();
`else
  logic [31:0] r_mem [DEPTH] = '{default: '0};
`endif

  logic             r_q_we    [QDEPTH];
  logic [TAG_W-1:0] r_q_tag   [QDEPTH];
  logic [AW-1:0]    r_q_idx   [QDEPTH];
  logic [31:0]      r_q_wdata [QDEPTH];
  logic [QAW-1:0]   r_wr_ptr;
  logic [QAW-1:0]   r_rd_ptr;
  logic [QAW:0]     r_count;
  logic             r_req_ready;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_svc_we;
  logic [TAG_W-1:0] r_svc_tag;
  logic [AW-1:0]    r_svc_idx;
  logic [31:0]      r_svc_wdata;

  logic             r_resp_valid;
  logic             r_resp_we;
  logic [TAG_W-1:0] r_resp_tag;
  logic [31:0]      r_resp_data;

  logic             w_push;
  logic             w_pop;
  logic             w_fire;
  logic             w_resp_done;
  logic             w_empty;
  logic [QAW:0]     w_count_nxt;
  logic [AW-1:0]    w_req_idx;
  logic             w_unused;

  assign w_req_idx   = req_addr[AW+1:2];
  assign w_unused    = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign w_empty     = (r_count == '0);
  assign w_push      = req_valid && r_req_ready;
  assign w_count_nxt = r_count + (QAW + 1)'(w_push) - (QAW + 1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_we[r_wr_ptr]    <= req_we;
      r_q_tag[r_wr_ptr]   <= req_tag;
      r_q_idx[r_wr_ptr]   <= w_req_idx;
      r_q_wdata[r_wr_ptr] <= req_wdata;
    end
  end

  // ready is registered from the post-edge count, so a pop on a full FIFO cannot bypass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt != Q_FULL);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_fire      = 1'b0;
    w_resp_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_fire      = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_resp_done = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_svc_we    <= 1'b0;
      r_svc_tag   <= '0;
      r_svc_idx   <= '0;
      r_svc_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_svc_we    <= r_q_we[r_rd_ptr];
        r_svc_tag   <= r_q_tag[r_rd_ptr];
        r_svc_idx   <= r_q_idx[r_rd_ptr];
        r_svc_wdata <= r_q_wdata[r_rd_ptr];
        r_cnt       <= CNT_LOAD;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // array has no reset so its contents survive rst
  always_ff @(posedge clk) begin
    if (w_fire && r_svc_we) r_mem[r_svc_idx] <= r_svc_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_tag   <= '0;
      r_resp_data  <= '0;
    end else if (w_fire) begin
      r_resp_valid <= 1'b1;
      r_resp_we    <= r_svc_we;
      r_resp_tag   <= r_svc_tag;
      r_resp_data  <= r_svc_we ? 32'h0 : r_mem[r_svc_idx];
    end else if (w_resp_done) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_we    = r_resp_we;
  assign resp_tag   = r_resp_tag;
  assign resp_data  = r_resp_data;
  assign busy       = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_main_mem.sv
// Directed plus randomized bench for main_mem; responses are scored against a transaction-level model.
module tb_main_mem;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 4;
  localparam int QDEPTH  = 2;
  localparam int TAG_W   = 2;
  localparam logic [127:0] INIT_IMAGE = {32'hA5A5A5A5, 96'h0};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      req_addr = '0;
  logic [31:0]      req_wdata = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic             resp_we;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_data;
  logic             busy;

  always #5 clk = ~clk;

  main_mem #(.DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(QDEPTH), .TAG_W(TAG_W),
             .INIT_N(4), .INIT_IMAGE(INIT_IMAGE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_tag(req_tag), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_tag(resp_tag), .resp_data(resp_data), .busy(busy)
  );

  typedef struct {
    logic             we;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    bit               known;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  exp_t        exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_accept();
    exp_t e;
    int   i;
    i = idx_of(req_addr);
    e.we  = req_we;
    e.tag = req_tag;
    if (req_we) begin
      m_mem[i]   = req_wdata;
      m_known[i] = 1'b1;
      e.data     = 32'h0;
      e.known    = 1'b1;
    end else begin
      e.data  = m_mem[i];
      e.known = m_known[i];
    end
    exp_q.push_back(e);
  endtask

  // One clock: score what the coming edge will transfer, then advance to 1ns past it.
  task automatic cycle();
    exp_t e;
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp", {31'b0, resp_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_we", {31'b0, resp_we}, {31'b0, e.we});
        chk("sb_tag", 32'(resp_tag), 32'(e.tag));
        if (e.known) chk("sb_data", resp_data, e.data);
      end
    end
    if (req_valid && req_ready) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [TAG_W-1:0] tag,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bit acc;
    int n;
    req_we = we; req_tag = tag; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      acc = req_ready;
      cycle();
      n++;
    end
    req_valid = 1'b0;
    chk("send_accept", {31'b0, acc}, 32'h1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!resp_valid && n < budget) begin
      cycle();
      n++;
    end
    chk("wait_valid", {31'b0, resp_valid}, 32'h1);
  endtask

  task automatic drain(input int budget);
    int n;
    resp_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 32'h0;
`ifdef MAIN_MEM_INIT_EN
      m_known[i] = 1'b0;
`else
      m_known[i] = 1'b1;
`endif
    end
`ifdef MAIN_MEM_INIT_EN
    m_mem[3]   = 32'hA5A5A5A5;
    m_known[3] = 1'b1;
`endif

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_we", {31'b0, resp_we}, 32'h0);
    chk("rst_resp_tag", 32'(resp_tag), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);

    // write then read, with exact latency
    resp_ready = 1'b0;
    send(1'b1, 2'd1, 32'h0000_0010, 32'hCAFE_F00D);
    for (int k = 1; k <= LATENCY; k++) begin
      cycle();
      chk("lat_low", {31'b0, resp_valid}, 32'h0);
    end
    cycle();
    chk("lat_high", {31'b0, resp_valid}, 32'h1);
    chk("wr_resp_we", {31'b0, resp_we}, 32'h1);
    chk("wr_resp_tag", 32'(resp_tag), 32'h1);
    chk("wr_resp_data", resp_data, 32'h0);
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    send(1'b0, 2'd2, 32'h0000_0010, 32'h0);
    wait_valid(20);
    chk("rd_data", resp_data, 32'hCAFE_F00D);
    chk("rd_tag", 32'(resp_tag), 32'h2);
    chk("rd_we", {31'b0, resp_we}, 32'h0);
    drain(20);

    // address wrap modulo DEPTH*4
    send(1'b1, 2'd0, 32'h0000_0020, 32'h1234_5678);
    drain(20);
    resp_ready = 1'b0;
    send(1'b0, 2'd3, 32'h0000_1020, 32'h0);
    wait_valid(20);
    chk("wrap_data", resp_data, 32'h1234_5678);
    drain(20);

    // FIFO full: A,B,C on consecutive edges, D held off until B is popped
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0; req_tag = 2'd0; req_addr = 32'h0000_0010;
    cycle();
    req_tag = 2'd1; req_addr = 32'h0000_0020;
    cycle();
    req_tag = 2'd2; req_addr = 32'h0000_0040;
    cycle();
    chk("full_ready", {31'b0, req_ready}, 32'h0);
    chk("full_busy", {31'b0, busy}, 32'h1);
    req_we = 1'b1; req_tag = 2'd3; req_addr = 32'h0000_0040; req_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("full_hold", {31'b0, req_ready}, 32'h0);
    end
    chk("full_a_valid", {31'b0, resp_valid}, 32'h1);
    chk("full_a_tag", 32'(resp_tag), 32'h0);
    chk("full_queued", 32'(exp_q.size()), 32'h3);
    resp_ready = 1'b1;
    cycle();
    chk("full_ready_rise", {31'b0, req_ready}, 32'h1);
    cycle();
    req_valid = 1'b0;
    chk("full_d_accepted", 32'(exp_q.size()), 32'h3);
    drain(60);

    // backpressure on a read response, then back-to-back follow-up
    resp_ready = 1'b0;
    send(1'b0, 2'd1, 32'h0000_0010, 32'h0);
    send(1'b0, 2'd2, 32'h0000_0020, 32'h0);
    wait_valid(20);
    e = exp_q[0];
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("bp_valid", {31'b0, resp_valid}, 32'h1);
      chk("bp_tag", 32'(resp_tag), 32'(e.tag));
      chk("bp_data", resp_data, e.data);
    end
    resp_ready = 1'b1;
    cycle();
    resp_ready = 1'b0;
    chk("bp_one_hs", {31'b0, resp_valid}, 32'h0);
    for (int k = 1; k < LATENCY; k++) begin
      cycle();
      chk("bp_next_low", {31'b0, resp_valid}, 32'h0);
    end
    cycle();
    chk("bp_next_valid", {31'b0, resp_valid}, 32'h1);
    chk("bp_next_tag", 32'(resp_tag), 32'h2);
    chk("bp_next_data", resp_data, 32'h1234_5678);
    drain(20);

    // reset while one request is in WAIT and one is queued
    resp_ready = 1'b1;
    send(1'b0, 2'd0, 32'h0000_0030, 32'h0);
    send(1'b0, 2'd1, 32'h0000_0034, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'h1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("post_rst_quiet", {31'b0, resp_valid}, 32'h0);
    end
    resp_ready = 1'b0;
    send(1'b0, 2'd2, 32'h0000_0010, 32'h0);
    wait_valid(20);
    chk("mem_kept", resp_data, 32'hCAFE_F00D);
    drain(20);

    // initial image word 3
    resp_ready = 1'b0;
    send(1'b0, 2'd3, 32'h0000_000C, 32'h0);
    wait_valid(20);
`ifdef MAIN_MEM_INIT_EN
    chk("init_word3", resp_data, 32'hA5A5A5A5);
`else
    chk("init_word3", resp_data, 32'h0);
`endif
    drain(20);

    // randomized traffic over a small window of words with random upper/lower address bits
    for (int k = 0; k < 400; k++) begin
      a = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      req_valid  = ($urandom_range(0, 1) == 1);
      req_we     = ($urandom_range(0, 1) == 1);
      req_tag    = TAG_W'($urandom_range(0, 3));
      req_addr   = a;
      req_wdata  = $urandom();
      resp_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    req_valid = 1'b0;
    drain(200);
    cycle();
    chk("final_idle", {31'b0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
